// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared funct3 size codes, FSM encoding and data width.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational byte-lane steering for stores and load extraction.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic              write_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdword_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_err;

  assign w_byte = rdword_i[{addr_i, 3'b000} +: 8];
  assign w_half = addr_i[1] ? rdword_i[31:16] : rdword_i[15:0];
  assign err_o  = w_err;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    w_err   = 1'b0;
    case (size_i)
      c_F3_B: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{w_byte[7]}}, w_byte};
      end
      c_F3_H: begin
        w_err   = addr_i[0];
        be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{w_half[15]}}, w_half};
      end
      c_F3_W: begin
        w_err   = |addr_i;
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdword_i;
      end
      // Unsigned forms exist only for loads.
      c_F3_BU: begin
        w_err   = write_i;
        rdata_o = {24'b0, w_byte};
      end
      c_F3_HU: begin
        w_err   = write_i | addr_i[0];
        rdata_o = {16'b0, w_half};
      end
      default: w_err = 1'b1;
    endcase
    if (w_err) begin
      be_o    = '0;
      rdata_o = '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Fixed-latency data-memory responder with pipeline stall and
//            RV32I byte/half/word access handling.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [2:0]        req_size_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              stall_o
);

  localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q;
  logic [c_IDX_W+1:0]    addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            size_q;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0]     rsp_rdata_q;
  logic [DATA_W-1:0]     mem_q [DEPTH_WORDS];

  logic                  w_accept, w_perform;
  logic                  w_acc_write;
  logic [c_IDX_W+1:0]    w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic [2:0]            w_acc_size;
  logic [c_IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]     w_rdword, w_st_word, w_ld_data, w_merged;
  logic [3:0]            w_be;
  logic                  w_err;
  logic                  w_unused_addr;

  assign w_unused_addr = ^req_addr_i[31:c_IDX_W+2];

  // With single-cycle latency the access happens on the acceptance edge,
  // so it must use the live request rather than the latched copy.
  assign w_acc_write = (LATENCY == 1) ? req_write_i                 : write_q;
  assign w_acc_addr  = (LATENCY == 1) ? req_addr_i[c_IDX_W+1:0]     : addr_q;
  assign w_acc_wdata = (LATENCY == 1) ? req_wdata_i                 : wdata_q;
  assign w_acc_size  = (LATENCY == 1) ? req_size_i                  : size_q;
  assign w_idx       = w_acc_addr[c_IDX_W+1:2];
  assign w_rdword    = mem_q[w_idx];

  dmem_lane_align u_align (
    .write_i  (w_acc_write),
    .size_i   (w_acc_size),
    .addr_i   (w_acc_addr[1:0]),
    .wdata_i  (w_acc_wdata),
    .rdword_i (w_rdword),
    .be_o     (w_be),
    .wdata_o  (w_st_word),
    .rdata_o  (w_ld_data),
    .err_o    (w_err)
  );

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_merged[8*b +: 8] = w_be[b] ? w_st_word[8*b +: 8] : w_rdword[8*b +: 8];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    w_accept  = 1'b0;
    w_perform = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            state_d   = ST_RESP;
            w_perform = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = c_CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_RESP;
          w_perform = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= (state_d == ST_RESP);
      if (w_accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i[c_IDX_W+1:0];
        wdata_q <= req_wdata_i;
        size_q  <= req_size_i;
      end
      if (w_perform) begin
        rsp_rdata_q <= w_acc_write ? '0 : w_ld_data;
        rsp_err_q   <= w_err;
      end
    end
  end

  // Storage is deliberately outside the reset domain; rst only blocks a
  // store that has not yet been performed.
  always_ff @(posedge clk) begin
    if (!rst && w_perform && w_acc_write && (|w_be)) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign stall_o     = ((state_q == ST_IDLE) && req_valid_i) || (state_q == ST_BUSY);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
`default_nettype wire
